spdif_sched: RTL and testbench
==============================

SPDIF_SCHED -- requirements
Module: spdif_sched

Interface
REQ-001 Parameter FIFO_LOG2, default 2: sample FIFO depth = 2**FIFO_LOG2 stereo entries.
REQ-002 Parameter MUTE_ACKS, default 4: number of tx_ack pulses of silence inserted on a source switch.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 src0_l, src0_r  in  24 each  source 0 sample; src0_valid in 1; src0_ready out 1.
REQ-007 src1_l, src1_r  in  24 each  source 1 sample; src1_valid in 1; src1_ready out 1.
REQ-008 cfg_enable  in  1  run request; cfg_sel  in  1  requested source; cfg_mute  in  1  force zero audio.
REQ-009 cfg_clr_ur  in  1  single-cycle pulse that clears the underrun counter.
REQ-010 tx_ack  in  1  single-cycle pulse from the SPDIF transmitter: current stereo pair consumed.
REQ-011 tx_l, tx_r  out  24 each  registered samples to the transmitter; tx_valid  out  1  sample-valid flag.
REQ-012 active_src  out  1  source currently feeding the FIFO; state  out  2  FSM state; underrun_cnt  out  16.

Function
REQ-013 FSM states SHALL be IDLE=0, FILL=1, RUN=2, SWITCH=3.
REQ-014 IDLE: FIFO flushed, both ready low, tx_l/tx_r=0, tx_valid=0; cfg_enable=1 -> FILL with active_src=cfg_sel.
REQ-015 cfg_enable=0 in any state -> IDLE on the next clk, FIFO flushed, tx_* zeroed on that same edge.
REQ-016 srcN_ready = (state is FILL or RUN) and active_src==N and FIFO not full; the non-active ready SHALL be 0.
REQ-017 Push occurs when srcN_valid and srcN_ready are both high for the active source.
REQ-018 FILL: tx_ack leaves tx_l/tx_r=0 and tx_valid=0, does not pop and does not count as underrun; FIFO full -> RUN.
REQ-019 RUN, tx_ack with FIFO non-empty: pop the head; the next clk loads tx_l/tx_r = head (or 0 if cfg_mute) and tx_valid=1.
REQ-020 RUN, tx_ack with FIFO empty: the next clk loads tx_l/tx_r=0 and tx_valid=0, and underrun_cnt increments; state stays RUN.
REQ-021 Push and pop in the same cycle SHALL leave the FIFO occupancy unchanged; a full FIFO deasserts ready even if a pop occurs that cycle.
REQ-022 cfg_sel != active_src in FILL or RUN -> SWITCH: FIFO flushed, both ready low, mute counter loaded with MUTE_ACKS.
REQ-023 SWITCH: each tx_ack loads tx_l/tx_r=0 and tx_valid=1 and decrements the counter; on the ack that reaches 0 -> FILL with active_src=cfg_sel sampled at that edge.
REQ-024 SWITCH: if cfg_sel returns to active_src before the count reaches 0, the switch SHALL still complete its full MUTE_ACKS.
REQ-025 underrun_cnt SHALL saturate at 16'hFFFF; cfg_clr_ur wins over a simultaneous increment (result 0).
REQ-026 tx_l, tx_r and tx_valid SHALL change only on the clk after tx_ack, on entry to IDLE, or on reset.
REQ-027 FIFO pointers SHALL be FIFO_LOG2+1 bits wide, with full/empty decided by MSB-differing/equal pointers.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, FIFO empty, active_src=0, mute counter=0, underrun_cnt=0, tx_l/tx_r=0, tx_valid=0, both ready low.
REQ-029 Reset released mid-stream SHALL discard all buffered samples; the first sample presented after reset SHALL be one pushed after re-entering FILL.

Verification
REQ-030 Enable with sel=0 and src0 streaming L=n, R=n+0x100 (n=1,2,...) -> src1_ready stays 0; after 4 pushes -> RUN; acks yield tx_l=1,2,3... with tx_valid=1 one clk after each ack.
REQ-031 In RUN, stop src0_valid and issue 6 acks -> 4 samples, then 2 pairs of 0/valid=0, underrun_cnt=2; cfg_clr_ur in the same cycle as a third underrun -> underrun_cnt=0.
REQ-032 In RUN, set cfg_sel=1 -> next clk state=3 and both ready low; 4 acks give 0/valid=1; after the 4th ack state=1, active_src=1, and only src1_ready is asserted.
REQ-033 With the FIFO full and src valid held, pulse tx_ack -> the same cycle pushes nothing (ready low), the next cycle ready is high and the push restores full.
REQ-034 cfg_mute=1 in RUN -> tx_l/tx_r=0 with tx_valid=1 and FIFO still popping; drop cfg_enable -> IDLE next clk, tx_*=0; pulse rst_n=0 mid-SWITCH -> all outputs at their reset values immediately.

Source files
------------

// File: rtl/spdif_sched.sv
// Stereo sample scheduler for an SPDIF transmitter: selects one of two sources into a small FIFO
// and hands out one stereo pair per transmitter ack, inserting silence on source changes.
module spdif_sched #(
    parameter int unsigned FIFO_LOG2 = 2,
    parameter int unsigned MUTE_ACKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] src0_l,
    input  logic [23:0] src0_r,
    input  logic        src0_valid,
    output logic        src0_ready,
    input  logic [23:0] src1_l,
    input  logic [23:0] src1_r,
    input  logic        src1_valid,
    output logic        src1_ready,
    input  logic        cfg_enable,
    input  logic        cfg_sel,
    input  logic        cfg_mute,
    input  logic        cfg_clr_ur,
    input  logic        tx_ack,
    output logic [23:0] tx_l,
    output logic [23:0] tx_r,
    output logic        tx_valid,
    output logic        active_src,
    output logic [1:0]  state,
    output logic [15:0] underrun_cnt
);

    localparam int unsigned Depth = 2 ** FIFO_LOG2;
    localparam int unsigned CntW  = (MUTE_ACKS > 1) ? $clog2(MUTE_ACKS + 1) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFill   = 2'd1,
        StRun    = 2'd2,
        StSwitch = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               active_q, active_d;
    logic [CntW-1:0]    mute_cnt_q, mute_cnt_d;
    logic [15:0]        ur_q, ur_d;
    logic [23:0]        tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic               tx_valid_q, tx_valid_d;
    logic [FIFO_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [47:0]        mem [Depth];

    logic        full, empty, feeding, push, pop, flush, ur_inc;
    logic [47:0] push_data, head;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                   (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);

    assign feeding    = (state_q == StFill) || (state_q == StRun);
    assign src0_ready = feeding && !active_q && !full;
    assign src1_ready = feeding && active_q && !full;
    assign push       = (src0_valid && src0_ready) || (src1_valid && src1_ready);
    assign push_data  = active_q ? {src1_l, src1_r} : {src0_l, src0_r};
    assign head       = mem[rd_ptr_q[FIFO_LOG2-1:0]];

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        mute_cnt_d = mute_cnt_q;
        tx_l_d     = tx_l_q;
        tx_r_d     = tx_r_q;
        tx_valid_d = tx_valid_q;
        flush      = 1'b0;
        pop        = 1'b0;
        ur_inc     = 1'b0;

        if (!cfg_enable) begin
            state_d    = StIdle;
            flush      = 1'b1;
            tx_l_d     = '0;
            tx_r_d     = '0;
            tx_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    flush    = 1'b1;
                    state_d  = StFill;
                    active_d = cfg_sel;
                end
                StFill, StRun: begin
                    if (tx_ack) begin
                        tx_l_d     = '0;
                        tx_r_d     = '0;
                        tx_valid_d = 1'b0;
                        if (state_q == StRun) begin
                            if (!empty) begin
                                pop        = 1'b1;
                                tx_l_d     = cfg_mute ? 24'd0 : head[47:24];
                                tx_r_d     = cfg_mute ? 24'd0 : head[23:0];
                                tx_valid_d = 1'b1;
                            end else begin
                                ur_inc = 1'b1;
                            end
                        end
                    end
                    if (cfg_sel != active_q) begin
                        state_d    = StSwitch;
                        flush      = 1'b1;
                        mute_cnt_d = CntW'(MUTE_ACKS);
                    end else if ((state_q == StFill) && full) begin
                        state_d = StRun;
                    end
                end
                StSwitch: begin
                    flush = 1'b1;
                    if (tx_ack) begin
                        tx_l_d     = '0;
                        tx_r_d     = '0;
                        tx_valid_d = 1'b1;
                        // Switch always runs its full silence count, whatever cfg_sel does meanwhile.
                        if (mute_cnt_q <= CntW'(1)) begin
                            mute_cnt_d = '0;
                            state_d    = StFill;
                            active_d   = cfg_sel;
                        end else begin
                            mute_cnt_d = mute_cnt_q - CntW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end

        ur_d = ur_q;
        if (cfg_clr_ur) begin
            ur_d = '0;
        end else if (ur_inc && (ur_q != 16'hFFFF)) begin
            ur_d = ur_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            active_q   <= 1'b0;
            mute_cnt_q <= '0;
            ur_q       <= '0;
            tx_l_q     <= '0;
            tx_r_q     <= '0;
            tx_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            mute_cnt_q <= mute_cnt_d;
            ur_q       <= ur_d;
            tx_l_q     <= tx_l_d;
            tx_r_q     <= tx_r_d;
            tx_valid_q <= tx_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[FIFO_LOG2-1:0]] <= push_data;
    end

    assign tx_l         = tx_l_q;
    assign tx_r         = tx_r_q;
    assign tx_valid     = tx_valid_q;
    assign active_src   = active_q;
    assign state        = state_q;
    assign underrun_cnt = ur_q;

endmodule

// File: tb/tb_spdif_sched.sv
// Self-checking bench for spdif_sched: scoreboard of pushed pairs checked at each tx_ack,
// plus a vector table walking a source switch.
module tb_spdif_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] src0_l, src0_r, src1_l, src1_r;
    logic        src0_valid, src0_ready, src1_valid, src1_ready;
    logic        cfg_enable, cfg_sel, cfg_mute, cfg_clr_ur, tx_ack;
    logic [23:0] tx_l, tx_r;
    logic        tx_valid, active_src;
    logic [1:0]  state;
    logic [15:0] underrun_cnt;

    always #5 clk = ~clk;

    spdif_sched #(.FIFO_LOG2(2), .MUTE_ACKS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .src0_l(src0_l), .src0_r(src0_r), .src0_valid(src0_valid), .src0_ready(src0_ready),
        .src1_l(src1_l), .src1_r(src1_r), .src1_valid(src1_valid), .src1_ready(src1_ready),
        .cfg_enable(cfg_enable), .cfg_sel(cfg_sel), .cfg_mute(cfg_mute),
        .cfg_clr_ur(cfg_clr_ur), .tx_ack(tx_ack),
        .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid),
        .active_src(active_src), .state(state), .underrun_cnt(underrun_cnt)
    );

    typedef struct {
        logic       ack;
        logic       sel;
        logic [1:0] st;
        logic       valid;
        logic       r0;
        logic       r1;
        logic       act;
    } sw_vec_t;

    sw_vec_t     sw_tab [7];
    logic [47:0] sb [$];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] s0_n, s1_n;

    assign src0_l = s0_n;
    assign src0_r = s0_n + 24'h100;
    assign src1_l = 24'h800000 | s1_n;
    assign src1_r = 24'h900000 | s1_n;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; records any handshake seen at the edge into the scoreboard.
    task automatic step();
        logic f0, f1;
        f0 = src0_valid && src0_ready;
        f1 = src1_valid && src1_ready;
        @(posedge clk);
        #1;
        if (f0) begin
            sb.push_back({src0_l, src0_r});
            s0_n = s0_n + 24'd1;
        end
        if (f1) begin
            sb.push_back({src1_l, src1_r});
            s1_n = s1_n + 24'd1;
        end
    endtask

    task automatic wait_state(input string name, input logic [1:0] target, input int budget);
        int n;
        n = 0;
        while (state !== target && n < budget) begin
            step();
            n++;
        end
        chk(name, 48'(state), 48'(target));
    endtask

    // Ack in RUN: head of scoreboard expected (zeroed if muted), else an underrun pair.
    task automatic do_ack(input string name);
        logic [47:0] e;
        logic        ev;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ev = 1'b1;
            if (cfg_mute) e = '0;
        end else begin
            e  = '0;
            ev = 1'b0;
        end
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        chk({name, "_data"}, {tx_l, tx_r}, e);
        chk({name, "_valid"}, 48'(tx_valid), 48'(ev));
    endtask

    initial begin
        logic r1_seen;
        int   n;

        // ack, sel, state, tx_valid, src0_ready, src1_ready, active_src
        sw_tab[0] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        sw_tab[1] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        sw_tab[2] = '{1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        sw_tab[3] = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        sw_tab[4] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        sw_tab[5] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1};
        sw_tab[6] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        src0_valid = 1'b0; src1_valid = 1'b0;
        cfg_enable = 1'b0; cfg_sel = 1'b0; cfg_mute = 1'b0; cfg_clr_ur = 1'b0; tx_ack = 1'b0;
        s0_n = 24'd1; s1_n = 24'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 48'(state), 48'd0);
        chk("rst_tx", {tx_l, tx_r}, 48'd0);
        chk("rst_valid", 48'(tx_valid), 48'd0);
        chk("rst_ready", 48'({src0_ready, src1_ready}), 48'd0);
        chk("rst_ur", 48'(underrun_cnt), 48'd0);
        chk("rst_active", 48'(active_src), 48'd0);
        rst_n = 1'b1;

        // Fill from source 0 while source 1 also offers data.
        cfg_enable = 1'b1; cfg_sel = 1'b0; src0_valid = 1'b1; src1_valid = 1'b1;
        step();
        chk("enter_fill", 48'(state), 48'd1);
        r1_seen = 1'b0;
        n = 0;
        while (state !== 2'd2 && n < 20) begin
            step();
            if (src1_ready) r1_seen = 1'b1;
            n++;
        end
        chk("fill_to_run", 48'(state), 48'd2);
        chk("src1_ready_quiet", 48'(r1_seen), 48'd0);
        chk("fill_count", 48'(sb.size()), 48'd4);

        do_ack("ack1");
        chk("ack1_l", 48'(tx_l), 48'd1);
        chk("ready_after_pop", 48'(src0_ready), 48'd1);
        step();
        chk("refilled_full", 48'(src0_ready), 48'd0);
        do_ack("ack2");
        do_ack("ack3");
        chk("ack3_l", 48'(tx_l), 48'd3);
        step();

        // Starve the FIFO to produce underruns.
        src0_valid = 1'b0;
        for (int i = 0; i < 6; i++) do_ack("drain");
        chk("ur_two", 48'(underrun_cnt), 48'd2);
        cfg_clr_ur = 1'b1;
        do_ack("ur_clr");
        cfg_clr_ur = 1'b0;
        chk("ur_clr_wins", 48'(underrun_cnt), 48'd0);
        do_ack("ur_again");
        chk("ur_one", 48'(underrun_cnt), 48'd1);
        chk("run_after_ur", 48'(state), 48'd2);

        // Mute keeps popping the FIFO.
        src0_valid = 1'b1;
        repeat (5) step();
        chk("refill_count", 48'(sb.size()), 48'd4);
        cfg_mute = 1'b1;
        do_ack("mute1");
        do_ack("mute2");
        cfg_mute = 1'b0;
        do_ack("unmute");
        cfg_mute = 1'b1;
        do_ack("mute3");
        src0_valid = 1'b0;

        // Source switch walk.
        sb.delete();
        for (int i = 0; i < 7; i++) begin
            tx_ack = sw_tab[i].ack;
            cfg_sel = sw_tab[i].sel;
            step();
            tx_ack = 1'b0;
            chk($sformatf("sw%0d_state", i), 48'(state), 48'(sw_tab[i].st));
            chk($sformatf("sw%0d_valid", i), 48'(tx_valid), 48'(sw_tab[i].valid));
            chk($sformatf("sw%0d_tx", i), {tx_l, tx_r}, 48'd0);
            chk($sformatf("sw%0d_r0", i), 48'(src0_ready), 48'(sw_tab[i].r0));
            chk($sformatf("sw%0d_r1", i), 48'(src1_ready), 48'(sw_tab[i].r1));
            chk($sformatf("sw%0d_act", i), 48'(active_src), 48'(sw_tab[i].act));
        end
        cfg_mute = 1'b0;

        src1_valid = 1'b1;
        wait_state("src1_run", 2'd2, 10);
        do_ack("src1_first");
        chk("src1_first_l", 48'(tx_l), 48'h800001);

        // Disable from RUN.
        cfg_enable = 1'b0;
        step();
        sb.delete();
        chk("dis_state", 48'(state), 48'd0);
        chk("dis_tx", {tx_l, tx_r}, 48'd0);
        chk("dis_valid", 48'(tx_valid), 48'd0);
        chk("dis_ready", 48'(src1_ready), 48'd0);

        // Reset asserted in the middle of a switch.
        cfg_enable = 1'b1; cfg_sel = 1'b1;
        step();
        repeat (2) step();
        src1_valid = 1'b0;
        cfg_sel = 1'b0;
        step();
        chk("pre_rst_switch", 48'(state), 48'd3);
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
        chk("pre_rst_valid", 48'(tx_valid), 48'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 48'(state), 48'd0);
        chk("arst_valid", 48'(tx_valid), 48'd0);
        chk("arst_active", 48'(active_src), 48'd0);
        chk("arst_ur", 48'(underrun_cnt), 48'd0);
        chk("arst_ready", 48'({src0_ready, src1_ready}), 48'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        src0_valid = 1'b1;
        step();
        wait_state("post_rst_run", 2'd2, 10);
        do_ack("post_rst_first");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
